trig_capture_mc: RTL
====================

// Module: trig_capture_mc
// PURPOSE
//  Multi-channel, single-clock, double-buffered triggered waveform capture. Writes nch lanes of gated samples
//  circularly into a write bank and freezes it after a trigger with a programmable pre-trigger depth.
//  Hands the bank to the reader, which addresses it chronologically (addr_r=0 is the oldest sample).
//  Sits between ADC/DSP sample streams and the local-bus readout.
// PARAMETERS
//  aw   10  log2 samples per bank (bank depth 2^aw)
//  dw   16  bits per channel sample
//  nch  2   channels captured in lockstep; memory word = nch*dw
// PORTS
//  clk              in   1       single clock for write and read sides
//  reset            in   1       asynchronous, active-high
//  data_w           in   nch*dw  sample word, ch0 in LSBs
//  data_gate_in     in   1       sample valid; only gated cycles write or advance counters
//  mode             in   2       0 free-run, 1 external rising edge, 2 software, 3 reserved (treated as 2)
//  arm              in   1       level; 1 allows a new capture to start
//  trig_ext         in   1       external trigger, already synchronous to clk
//  trig_sw          in   1       software trigger pulse
//  pre_len          in   aw      pre-trigger samples; sampled on IDLE->PRE and on each swap
//  trig_out         out  1       1-cycle pulse: trigger accepted
//  full_flag        out  1       write bank complete, waiting for the reader bank (state DONE)
//  r_bank_available out  1       reader owns a completed bank
//  stb_r            in   1       read strobe
//  addr_r           in   aw      chronological read index
//  rd_release       in   1       reader returns its bank
//  data_r           out  nch*dw  read data, held between reads
//  data_gate_out    out  1       data_r valid (1 cycle after stb_r)
//  buf_count        out  16      completed captures handed to the reader, wraps
//  ovf_count        out  16      triggers refused in DONE, saturates at 16'hFFFF
//  buf_stat         out  2       write state: 0 IDLE, 1 PRE, 2 POST, 3 DONE
// BEHAVIOUR
//  Reset (asynchronous): every output is 0 and the write state is IDLE. w_bank=0. The reader owns no bank.
//    All counters clear. Memory contents are kept. A reset mid-capture abandons the capture and does not count it.
//  IDLE: -> PRE when arm=1. pre_len is latched and fill=0.
//  PRE: each gated sample writes {w_bank,w_addr}, w_addr++ (wraps mod 2^aw), and fill saturates at pre_len.
//    A trigger is eligible on a gated cycle with fill>=pre_len.
//    mode0: eligible always. mode1: a latched rising edge. mode2: a latched trig_sw.
//    Edges and pulses seen while fill<pre_len are discarded. After fill>=pre_len they are held until the
//    next gated cycle.
//  On an accepted trigger: trig_out pulses the next cycle, start=w_addr-pre_len (mod 2^aw), post=1, and -> POST.
//    The trigger sample is the one written in that cycle, at chronological index pre_len.
//  POST: gated samples are written and post++. When the sample making post==2^aw-pre_len is written -> DONE.
//  DONE: write is disabled and full_flag=1. Triggers arriving here increment ovf_count.
//    Swap occurs in any DONE cycle where the reader owns no bank, including the cycle rd_release arrives.
//    Swap: r_bank<=w_bank, r_start<=start, w_bank flips, r_bank_available=1 next cycle, buf_count++.
//    Then -> PRE (arm=1, pre_len relatched) or -> IDLE.
//  arm=0 in PRE or POST lets the current capture finish. It only blocks restarting.
//  Read: when stb_r&r_bank_available, mem addr={r_bank, r_start+addr_r}. data_r and data_gate_out follow 1 cycle later.
//    stb_r is ignored when no bank is available, and data_gate_out stays 0.
//    data_r holds its last valid value otherwise.
//  rd_release with r_bank_available=1 clears it next cycle. With no bank it is ignored.
//    rd_release and stb_r in the same cycle: the read completes and data is delivered.
//  pre_len=0: trigger sample at index 0. pre_len=2^aw-1: a single post sample (the trigger itself).
// STRUCTURE
//  Shared include trig_capture_defs.vh: mode encodings (MODE_FREE/EXT/SW) and state encodings (ST_IDLE/PRE/POST/DONE).
//  Memory is the existing dpram with aw+1 address bits and nch*dw data width, with clka=clkb=clk.
//  Write FSM, trigger qualifier and read addressing stay in this module. No other sub-module.
// TESTING
//  aw=4, nch=2, mode0, pre_len=4, continuous gate, ramp data -> trig_out at the 5th sample.
//    Reader sees a 16-sample ramp, and index 4 holds the trigger sample. buf_count=1.
//  mode1, pre_len=8, trig_ext edge after only 3 samples, then again after 12 samples -> the first is ignored.
//    The capture is centred on the second edge. trig_out pulses once.
//  Gate toggling 1/0 -> only gated samples are stored, and the capture spans 32 clocks for 16 samples.
//  Reader never releases, mode0 -> bank 2 stays in DONE and full_flag=1. Extra triggers make ovf_count count.
//    On rd_release the swap happens in the same cycle and buf_count=2.
//  Reset asserted mid-POST -> state IDLE and outputs 0 immediately, without waiting for clk. Re-arm gives a clean capture.
//  stb_r with addr_r=15 -> data one cycle later. Wrap via r_start is correct, and stb_r after release gives no data_gate_out.

Source files
------------

// File: rtl/trig_capture_mc_pkg.sv
// Shared types for the triggered capture block: write-FSM states, trigger modes, counter width.
package trig_capture_mc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StPost = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ModeFree = 2'd0,
    ModeExt  = 2'd1,
    ModeSw   = 2'd2,
    ModeRsvd = 2'd3
  } mode_e;

  localparam int unsigned CountW = 16;

  function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trig_capture_mc_if.sv
// Sample stream, trigger control, status and readout signals of trig_capture_mc.
interface trig_capture_mc_if
  import trig_capture_mc_pkg::*;
#(
  parameter int unsigned aw  = 10,
  parameter int unsigned dw  = 16,
  parameter int unsigned nch = 2
);
  logic [nch*dw-1:0] data_w;
  logic              data_gate_in;
  logic [1:0]        mode;
  logic              arm;
  logic              trig_ext;
  logic              trig_sw;
  logic [aw-1:0]     pre_len;
  logic              trig_out;
  logic              full_flag;
  logic              r_bank_available;
  logic              stb_r;
  logic [aw-1:0]     addr_r;
  logic              rd_release;
  logic [nch*dw-1:0] data_r;
  logic              data_gate_out;
  logic [CountW-1:0] buf_count;
  logic [CountW-1:0] ovf_count;
  logic [1:0]        buf_stat;

  modport master (
    output data_w, data_gate_in, mode, arm, trig_ext, trig_sw, pre_len, stb_r, addr_r, rd_release,
    input  trig_out, full_flag, r_bank_available, data_r, data_gate_out, buf_count, ovf_count,
           buf_stat
  );

  modport slave (
    input  data_w, data_gate_in, mode, arm, trig_ext, trig_sw, pre_len, stb_r, addr_r, rd_release,
    output trig_out, full_flag, r_bank_available, data_r, data_gate_out, buf_count, ovf_count,
           buf_stat
  );
endinterface

// File: rtl/trig_capture_mc_dpram.sv
// Simple dual-port RAM: synchronous write on port A, registered read with enable on port B.
module trig_capture_mc_dpram #(
  parameter int unsigned AddrW = 11,
  parameter int unsigned DataW = 32
) (
  input  logic             clka_i,
  input  logic             wea_i,
  input  logic [AddrW-1:0] addra_i,
  input  logic [DataW-1:0] dina_i,
  input  logic             clkb_i,
  input  logic             rstb_i,
  input  logic             enb_i,
  input  logic [AddrW-1:0] addrb_i,
  output logic [DataW-1:0] doutb_o
);
  logic [DataW-1:0] mem_q [0:(1 << AddrW)-1];
  logic [DataW-1:0] doutb_q;

  always_ff @(posedge clka_i) begin
    if (wea_i) mem_q[addra_i] <= dina_i;
  end

  // Only the output register resets; the array keeps its contents.
  always_ff @(posedge clkb_i or posedge rstb_i) begin
    if (rstb_i) begin
      doutb_q <= '0;
    end else if (enb_i) begin
      doutb_q <= mem_q[addrb_i];
    end
  end

  assign doutb_o = doutb_q;
endmodule

// File: rtl/trig_capture_mc.sv
// Double-buffered multi-channel triggered capture: circular pre-trigger fill, post-trigger fill,
// bank hand-off to the reader and chronological readout.
module trig_capture_mc
  import trig_capture_mc_pkg::*;
#(
  parameter int unsigned aw  = 10,
  parameter int unsigned dw  = 16,
  parameter int unsigned nch = 2
) (
  input logic              clk,
  input logic              reset,
  trig_capture_mc_if.slave bus
);
  localparam logic [aw:0] BankDepth = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] PostOne   = {{aw{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              w_bank_q, w_bank_d, r_bank_q, r_bank_d, r_avail_q, r_avail_d;
  logic [aw-1:0]     w_addr_q, w_addr_d, fill_q, fill_d, pre_len_q, pre_len_d;
  logic [aw-1:0]     start_q, start_d, r_start_q, r_start_d;
  logic [aw:0]       post_q, post_d, post_target;
  logic              trig_out_q, trig_out_d;
  logic              ext_prev_q, ext_pend_q, ext_pend_d, sw_pend_q, sw_pend_d;
  logic [CountW-1:0] buf_count_q, buf_count_d, ovf_count_q, ovf_count_d;
  logic              rd_valid_q;
  mode_e             mode;
  logic              ext_rise, trig_ready, trig_hit, trig_accept, done_evt, wr_en, rd_en;
  logic [aw:0]       rd_addr;
  logic [nch*dw-1:0] rd_data;

  assign mode        = mode_e'(bus.mode);
  assign ext_rise    = bus.trig_ext & ~ext_prev_q;
  assign trig_ready  = (state_q == StPre) && (fill_q >= pre_len_q);
  assign post_target = BankDepth - {1'b0, pre_len_q};
  assign trig_accept = trig_ready & bus.data_gate_in & trig_hit;
  assign wr_en       = bus.data_gate_in & ((state_q == StPre) || (state_q == StPost));
  assign rd_en       = bus.stb_r & r_avail_q;
  assign rd_addr     = {r_bank_q, r_start_q + bus.addr_r};

  // done_evt is what counts as a refused trigger while the write bank is full.
  always_comb begin
    trig_hit = 1'b0;
    done_evt = 1'b0;
    unique case (mode)
      ModeFree: begin
        trig_hit = 1'b1;
        done_evt = bus.data_gate_in;
      end
      ModeExt: begin
        trig_hit = ext_rise | ext_pend_q;
        done_evt = ext_rise;
      end
      default: begin
        trig_hit = bus.trig_sw | sw_pend_q;
        done_evt = bus.trig_sw;
      end
    endcase
  end

  // Events are only remembered once pre-fill is satisfied, and only until the next gated cycle.
  always_comb begin
    ext_pend_d = 1'b0;
    sw_pend_d  = 1'b0;
    if (trig_ready && !bus.data_gate_in) begin
      ext_pend_d = ext_pend_q | ext_rise;
      sw_pend_d  = sw_pend_q | bus.trig_sw;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_bank_d    = w_bank_q;
    w_addr_d    = w_addr_q;
    fill_d      = fill_q;
    pre_len_d   = pre_len_q;
    start_d     = start_q;
    post_d      = post_q;
    r_bank_d    = r_bank_q;
    r_start_d   = r_start_q;
    r_avail_d   = r_avail_q;
    trig_out_d  = 1'b0;
    buf_count_d = buf_count_q;
    ovf_count_d = ovf_count_q;

    if (bus.rd_release && r_avail_q) r_avail_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.arm) begin
          state_d   = StPre;
          pre_len_d = bus.pre_len;
          fill_d    = '0;
        end
      end
      StPre: begin
        if (bus.data_gate_in) begin
          w_addr_d = w_addr_q + 1'b1;
          if (fill_q < pre_len_q) fill_d = fill_q + 1'b1;
          if (trig_accept) begin
            trig_out_d = 1'b1;
            start_d    = w_addr_q - pre_len_q;
            post_d     = PostOne;
            state_d    = (post_target == PostOne) ? StDone : StPost;
          end
        end
      end
      StPost: begin
        if (bus.data_gate_in) begin
          w_addr_d = w_addr_q + 1'b1;
          post_d   = post_q + 1'b1;
          if ((post_q + 1'b1) == post_target) state_d = StDone;
        end
      end
      StDone: begin
        if (done_evt) ovf_count_d = sat_inc(ovf_count_q);
        // A release in this cycle frees the reader bank, so the swap need not wait.
        if (!r_avail_q || bus.rd_release) begin
          r_bank_d    = w_bank_q;
          r_start_d   = start_q;
          r_avail_d   = 1'b1;
          w_bank_d    = ~w_bank_q;
          buf_count_d = buf_count_q + 1'b1;
          if (bus.arm) begin
            state_d   = StPre;
            pre_len_d = bus.pre_len;
            fill_d    = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      w_bank_q    <= 1'b0;
      w_addr_q    <= '0;
      fill_q      <= '0;
      pre_len_q   <= '0;
      start_q     <= '0;
      post_q      <= '0;
      r_bank_q    <= 1'b0;
      r_start_q   <= '0;
      r_avail_q   <= 1'b0;
      trig_out_q  <= 1'b0;
      ext_prev_q  <= 1'b0;
      ext_pend_q  <= 1'b0;
      sw_pend_q   <= 1'b0;
      buf_count_q <= '0;
      ovf_count_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_bank_q    <= w_bank_d;
      w_addr_q    <= w_addr_d;
      fill_q      <= fill_d;
      pre_len_q   <= pre_len_d;
      start_q     <= start_d;
      post_q      <= post_d;
      r_bank_q    <= r_bank_d;
      r_start_q   <= r_start_d;
      r_avail_q   <= r_avail_d;
      trig_out_q  <= trig_out_d;
      ext_prev_q  <= bus.trig_ext;
      ext_pend_q  <= ext_pend_d;
      sw_pend_q   <= sw_pend_d;
      buf_count_q <= buf_count_d;
      ovf_count_q <= ovf_count_d;
      rd_valid_q  <= rd_en;
    end
  end

  trig_capture_mc_dpram #(
    .AddrW(aw + 1),
    .DataW(nch * dw)
  ) u_mem (
    .clka_i (clk),
    .wea_i  (wr_en),
    .addra_i({w_bank_q, w_addr_q}),
    .dina_i (bus.data_w),
    .clkb_i (clk),
    .rstb_i (reset),
    .enb_i  (rd_en),
    .addrb_i(rd_addr),
    .doutb_o(rd_data)
  );

  assign bus.trig_out         = trig_out_q;
  assign bus.full_flag        = (state_q == StDone);
  assign bus.r_bank_available = r_avail_q;
  assign bus.data_r           = rd_data;
  assign bus.data_gate_out    = rd_valid_q;
  assign bus.buf_count        = buf_count_q;
  assign bus.ovf_count        = ovf_count_q;
  assign bus.buf_stat         = state_q;
endmodule
